pll_lock_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/sync_ff.sv | 28 ++
 rtl/pll_lock_sequencer.sv | 150 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2,
        FAIL      = 2'd3
    } pll_state_t;

    localparam int DEF_RST_CYCLES     = 16;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES    = 3;
    localparam int DEF_SYNC_STAGES    = 2;

    // Bits needed to hold a count running 0 .. cycles-1 (at least one bit).
    function automatic int cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous level input; chain resets to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset/lock and releases a system reset once lock is stable.
// Optional lock-loss counter output enabled by PLL_LOCK_LOSS_COUNT_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               lock_i,
    output logic                               pll_reset,
    output logic                               rst_out,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retries
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]                         loss_cnt
`endif
);

    localparam int CNT_W = cnt_width((RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES);
    localparam int STB_W = cnt_width(STABLE_CYCLES);
    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRIES);

    logic lock_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (lock_i),
        .q   (lock_s)
    );

    pll_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic [RET_W-1:0] retries_q, retries_d, retries_inc;
    logic [7:0]       loss_q, loss_d;
    logic             pll_reset_q, pll_reset_d;
    logic             rst_out_q, rst_out_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        retries_d   = retries_q;
        loss_d      = loss_q;
        retries_inc = retries_q + 1'b1;

        // cnt doubles as the PLL_RST hold counter and the WAIT_LOCK timeout counter.
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = '0;
                    stable_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                cnt_d    = cnt_q + 1'b1;
                stable_d = lock_s ? stable_q + 1'b1 : '0;
                if (lock_s && stable_q == STB_LAST) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    stable_d  = '0;
                    retries_d = '0;
                end else if (cnt_q == TMO_LAST) begin
                    retries_d = retries_inc;
                    state_d   = (retries_inc == RET_MAX) ? FAIL : PLL_RST;
                    cnt_d     = '0;
                    stable_d  = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they change on the transition edge.
        pll_reset_d = (state_d == PLL_RST) || (state_d == FAIL);
        rst_out_d   = (state_d != RUN);
        ready_d     = (state_d == RUN);
        fail_d      = (state_d == FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            stable_q    <= '0;
            retries_q   <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            retries_q   <= retries_d;
            loss_q      <= loss_d;
            pll_reset_q <= pll_reset_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retries   = retries_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    assign loss_cnt = loss_q;
`else
    logic unused_loss;
    assign unused_loss = ^loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_i = 1'b0;
    logic       pll_reset;
    logic       rst_out;
    logic       ready;
    logic       fail;
    logic [1:0] retries;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] loss_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES     (4),
        .STABLE_CYCLES  (8),
        .TIMEOUT_CYCLES (64),
        .MAX_RETRIES    (2),
        .SYNC_STAGES    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lock_i    (lock_i),
        .pll_reset (pll_reset),
        .rst_out   (rst_out),
        .ready     (ready),
        .fail      (fail),
        .retries   (retries)
`ifdef PLL_LOCK_LOSS_COUNT_EN
        ,
        .loss_cnt  (loss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0d at %0t", tag, obs, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        lock_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_pll_reset"}, 32'(pll_reset), 32'd1);
        check({pfx, "_rst_out"},   32'(rst_out),   32'd1);
        check({pfx, "_ready"},     32'(ready),     32'd0);
        check({pfx, "_fail"},      32'(fail),      32'd0);
        check({pfx, "_retries"},   32'(retries),   32'd0);
    endtask

    initial begin
        // Reset state
        ticks(3);
        check_reset_values("por");
        rst = 1'b0;

        // Clean lock
        ticks(3);
        check("clean_pllrst_hold", 32'(pll_reset), 32'd1);
        tick();
        check("clean_pllrst_rel", 32'(pll_reset), 32'd0);
        check("clean_wait_rstout", 32'(rst_out), 32'd1);
        ticks(5);
        lock_i = 1'b1;
        ticks(9);
        check("clean_rstout_pre", 32'(rst_out), 32'd1);
        check("clean_ready_pre", 32'(ready), 32'd0);
        tick();
        check("clean_rstout_rel", 32'(rst_out), 32'd0);
        check("clean_ready", 32'(ready), 32'd1);
        check("clean_retries", 32'(retries), 32'd0);
        check("clean_pll_reset", 32'(pll_reset), 32'd0);

        // Lock loss in RUN for 3 cycles, then relock
        ticks(3);
        lock_i = 1'b0;
        ticks(2);
        check("loss_rstout_pre", 32'(rst_out), 32'd0);
        check("loss_ready_pre", 32'(ready), 32'd1);
        tick();
        check("loss_rstout", 32'(rst_out), 32'd1);
        check("loss_ready", 32'(ready), 32'd0);
        check("loss_pll_reset", 32'(pll_reset), 32'd1);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("loss_cnt", 32'(loss_cnt), 32'd1);
`endif
        lock_i = 1'b1;
        ticks(11);
        check("relock_rstout_pre", 32'(rst_out), 32'd1);
        tick();
        check("relock_rstout", 32'(rst_out), 32'd0);
        check("relock_retries", 32'(retries), 32'd0);

        // Mid-operation reset with stable count at 5
        do_reset();
        ticks(4);
        lock_i = 1'b1;
        ticks(7);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        ticks(3);
        check("midrst_pllrst_hold", 32'(pll_reset), 32'd1);
        tick();
        check("midrst_pllrst_rel", 32'(pll_reset), 32'd0);
        ticks(7);
        check("midrst_rstout_pre", 32'(rst_out), 32'd1);
        tick();
        check("midrst_rstout_rel", 32'(rst_out), 32'd0);

        // Glitchy lock: 5 high, 1 low, then high
        do_reset();
        ticks(4);
        lock_i = 1'b1;
        ticks(5);
        lock_i = 1'b0;
        tick();
        lock_i = 1'b1;
        ticks(9);
        check("glitch_rstout_pre", 32'(rst_out), 32'd1);
        tick();
        check("glitch_rstout_rel", 32'(rst_out), 32'd0);
        check("glitch_ready", 32'(ready), 32'd1);

        // Timeout then success
        do_reset();
        ticks(67);
        check("tmo_retries_pre", 32'(retries), 32'd0);
        check("tmo_pllrst_pre", 32'(pll_reset), 32'd0);
        tick();
        check("tmo_retries", 32'(retries), 32'd1);
        check("tmo_pllrst", 32'(pll_reset), 32'd1);
        check("tmo_rstout", 32'(rst_out), 32'd1);
        ticks(3);
        check("tmo_pllrst_hold", 32'(pll_reset), 32'd1);
        tick();
        check("tmo_pllrst_rel", 32'(pll_reset), 32'd0);
        lock_i = 1'b1;
        ticks(9);
        check("tmo_retries_hold", 32'(retries), 32'd1);
        check("tmo_rstout_pre", 32'(rst_out), 32'd1);
        tick();
        check("tmo_retries_clr", 32'(retries), 32'd0);
        check("tmo_ready", 32'(ready), 32'd1);

        // Persistent failure
        do_reset();
        ticks(135);
        check("fail_pre", 32'(fail), 32'd0);
        check("fail_retries_pre", 32'(retries), 32'd1);
        tick();
        check("fail_flag", 32'(fail), 32'd1);
        check("fail_pll_reset", 32'(pll_reset), 32'd1);
        check("fail_rstout", 32'(rst_out), 32'd1);
        check("fail_retries", 32'(retries), 32'd2);
        check("fail_ready", 32'(ready), 32'd0);
        lock_i = 1'b1;
        ticks(20);
        check("fail_sticky", 32'(fail), 32'd1);
        check("fail_sticky_ready", 32'(ready), 32'd0);
        do_reset();
        check_reset_values("fail_exit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
